// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with redirect flush and decode handshake
//
// Purpose:
//   Holds the program counter and drives it straight to a combinational instruction
//   ROM. The fetched word, its address and the address plus 4 are registered into
//   a fetch packet for the decode stage. A taken branch or jump (redirect) flushes
//   the packet and reloads the PC. The PC is always word aligned.
//
// Ports:
//   clk             in   1   single clock, all state on rising edge
//   rst             in   1   synchronous active-high reset
//   rom_addr        out  32  byte address to instruction ROM (equals PC)
//   rom_dout        in   32  instruction word for rom_addr, same cycle
//   redirect_valid  in   1   branch/jump taken, load redirect_target
//   redirect_target in   32  byte address of next instruction on redirect
//   ready_in        in   1   decode accepts the current fetch packet
//   valid_out       out  1   fetch packet is valid
//   instr_out       out  32  registered instruction word
//   pc_out          out  32  registered address of instr_out
//   pc_plus4_out    out  32  registered pc_out + 4
//   misalign_out    out  1   one-cycle pulse on misaligned redirect target
//
// Configuration:
//   FETCH_MISALIGN_TRAP_EN  when defined, misaligned redirect targets pulse
//                           misalign_out; otherwise misalign_out is tied to 0
//                           and target bits [1:0] are silently dropped.

module fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter logic [31:0] NOP_INSTR    = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_dout,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        ready_in,
    output logic        valid_out,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4_out,
    output logic        misalign_out
);

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_valid;
    logic [31:0] r_instr;
    logic [31:0] r_pc_out;
    logic [31:0] r_pc_plus4;

    logic        w_adv;
    logic [31:0] w_pc_next;
    logic [31:0] w_target_aligned;

    // A slot opens when the packet register is empty or decode takes it. BOOT
    // always has an empty packet register, so it advances unconditionally.
    assign w_adv            = (r_state == ST_BOOT) || !r_valid || ready_in;
    // Plain 32-bit add wraps modulo 2^32 with no carry out.
    assign w_pc_next        = r_pc + 32'd4;
    assign w_target_aligned = {redirect_target[31:2], 2'b00};

    assign rom_addr     = r_pc;
    assign valid_out    = r_valid;
    assign instr_out    = r_instr;
    assign pc_out       = r_pc_out;
    assign pc_plus4_out = r_pc_plus4;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_BOOT;
            r_pc       <= RESET_VECTOR;
            r_valid    <= 1'b0;
            r_instr    <= NOP_INSTR;
            r_pc_out   <= 32'd0;
            r_pc_plus4 <= 32'd0;
        end else if (redirect_valid) begin
            // Flush: the packet in flight is wrong-path. pc_out/pc_plus4_out keep
            // their last values; they are meaningless while valid_out is low.
            r_state <= ST_RUN;
            r_pc    <= w_target_aligned;
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
        end else if (w_adv) begin
            r_state    <= ST_RUN;
            r_pc       <= w_pc_next;
            r_valid    <= 1'b1;
            r_instr    <= rom_dout;
            r_pc_out   <= r_pc;
            r_pc_plus4 <= w_pc_next;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    logic r_misalign;

    // Pulse lasts only the cycle after the redirect edge: any non-redirect
    // edge clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= redirect_valid && (redirect_target[1:0] != 2'b00);
        end
    end

    assign misalign_out = r_misalign;
`else
    assign misalign_out = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit: directed table plus randomized model check

module tb_fetch_unit;

    localparam logic [31:0] RV  = 32'hBFC00000;
    localparam logic [31:0] NOP = 32'h00000013;
`ifdef FETCH_MISALIGN_TRAP_EN
    localparam logic MIS_EN = 1'b1;
`else
    localparam logic MIS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] rom_addr;
    logic [31:0] rom_dout;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'd0;
    logic        ready_in = 1'b0;
    logic        valid_out;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4_out;
    logic        misalign_out;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        if (a == RV) return 32'h00500093;
        return {a[15:0], ~a[31:16]} ^ 32'h13579BDF;
    endfunction

    assign rom_dout = rom_word(rom_addr);

    fetch_unit #(.RESET_VECTOR(RV), .NOP_INSTR(NOP)) dut (
        .clk             (clk),
        .rst             (rst),
        .rom_addr        (rom_addr),
        .rom_dout        (rom_dout),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .ready_in        (ready_in),
        .valid_out       (valid_out),
        .instr_out       (instr_out),
        .pc_out          (pc_out),
        .pc_plus4_out    (pc_plus4_out),
        .misalign_out    (misalign_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        redir;
        logic [31:0] tgt;
        logic        ready;
        logic        ev;
        logic        chk_pc;
        logic [31:0] epc;
        logic [31:0] eaddr;
        logic        emis;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic rd, input logic [31:0] t, input logic rdy,
                       input logic ev, input logic cp, input logic [31:0] epc,
                       input logic [31:0] ea, input logic em);
        vec_t v;
        v.rst = r; v.redir = rd; v.tgt = t; v.ready = rdy; v.ev = ev; v.chk_pc = cp;
        v.epc = epc; v.eaddr = ea; v.emis = em;
        vecs.push_back(v);
    endtask

    // Reference model state: the fetch packet the decode stage should see and the PC.
    logic [31:0] m_pc, m_instr, m_pco, m_pc4;
    logic        m_valid, m_mis;

    task automatic model_edge(input logic r, input logic rd, input logic [31:0] t, input logic rdy);
        if (r) begin
            m_pc = RV; m_valid = 0; m_instr = NOP; m_pco = 0; m_pc4 = 0; m_mis = 0;
        end else if (rd) begin
            m_pc = t & 32'hFFFFFFFC; m_valid = 0; m_instr = NOP;
            m_mis = MIS_EN & (t[1:0] != 2'b00);
        end else begin
            m_mis = 0;
            if (!m_valid || rdy) begin
                m_instr = rom_word(m_pc); m_pco = m_pc; m_pc4 = m_pc + 32'd4;
                m_valid = 1; m_pc = m_pc + 32'd4;
            end
        end
    endtask

    initial begin
        logic        r, rd, rdy;
        logic [31:0] t;
        logic [31:0] hold_addr;

        // Directed table: inputs applied before the edge, outputs checked after it.
        add(1, 0, 0,            0, 0, 1, 32'd0,        RV,            0);
        add(0, 0, 0,            1, 1, 1, RV,           RV + 4,        0);
        add(0, 0, 0,            1, 1, 1, RV + 4,       RV + 8,        0);
        add(0, 0, 0,            0, 1, 1, RV + 4,       RV + 8,        0);
        add(0, 0, 0,            0, 1, 1, RV + 4,       RV + 8,        0);
        add(0, 0, 0,            0, 1, 1, RV + 4,       RV + 8,        0);
        add(0, 0, 0,            1, 1, 1, RV + 8,       RV + 12,       0);
        add(0, 1, 32'hBFC00040, 0, 0, 0, 0,            32'hBFC00040,  0);
        add(0, 0, 0,            0, 1, 1, 32'hBFC00040, 32'hBFC00044,  0);
        add(0, 1, 32'hFFFFFFFC, 1, 0, 0, 0,            32'hFFFFFFFC,  0);
        add(0, 0, 0,            1, 1, 1, 32'hFFFFFFFC, 32'h00000000,  0);
        add(0, 0, 0,            1, 1, 1, 32'h00000000, 32'h00000004,  0);
        add(0, 1, 32'hBFC00042, 1, 0, 0, 0,            32'hBFC00040,  MIS_EN);
        add(0, 0, 0,            1, 1, 1, 32'hBFC00040, 32'hBFC00044,  0);
        add(0, 1, 32'h00000100, 1, 0, 0, 0,            32'h00000100,  0);
        add(0, 1, 32'h00000200, 1, 0, 0, 0,            32'h00000200,  0);
        add(0, 0, 0,            1, 1, 1, 32'h00000200, 32'h00000204,  0);
        add(1, 1, 32'h00000300, 1, 0, 1, 32'd0,        RV,            0);
        add(0, 0, 0,            0, 1, 1, RV,           RV + 4,        0);
        add(1, 0, 0,            1, 0, 1, 32'd0,        RV,            0);
        add(0, 1, 32'h00000080, 0, 0, 0, 0,            32'h00000080,  0);
        add(0, 0, 0,            0, 1, 1, 32'h00000080, 32'h00000084,  0);

        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; redirect_valid = vecs[i].redir;
            redirect_target = vecs[i].tgt; ready_in = vecs[i].ready;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d valid", i), {31'd0, valid_out}, {31'd0, vecs[i].ev});
            check($sformatf("vec%0d rom_addr", i), rom_addr, vecs[i].eaddr);
            check($sformatf("vec%0d misalign", i), {31'd0, misalign_out}, {31'd0, vecs[i].emis});
            check($sformatf("vec%0d instr", i), instr_out,
                  vecs[i].ev ? rom_word(vecs[i].epc) : NOP);
            if (vecs[i].chk_pc) begin
                check($sformatf("vec%0d pc_out", i), pc_out, vecs[i].epc);
                check($sformatf("vec%0d pc_plus4", i), pc_plus4_out,
                      vecs[i].ev ? vecs[i].epc + 32'd4 : 32'd0);
            end
        end

        // Hand sequence: long stall keeps rom_addr and the packet frozen.
        rst = 0; redirect_valid = 0; ready_in = 1;
        @(posedge clk); #1;
        hold_addr = rom_addr;
        ready_in = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("stall rom_addr", rom_addr, hold_addr);
            check("stall pc_out", pc_out, hold_addr - 32'd4);
        end
        ready_in = 1;
        @(posedge clk); #1;
        check("stall release pc_out", pc_out, hold_addr);

        // Randomized phase against the reference model, starting from reset.
        for (int c = 0; c < 3000; c++) begin
            r   = (c == 0) || ($urandom_range(0, 99) == 0);
            rd  = ($urandom_range(0, 9) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       t = 32'hFFFFFFF0 | ($urandom & 32'hF);
                1:       t = RV + ($urandom & 32'hFF);
                default: t = $urandom;
            endcase
            rst = r; redirect_valid = rd; redirect_target = t; ready_in = rdy;
            @(posedge clk);
            model_edge(r, rd, t, rdy);
            #1;
            check("rnd valid", {31'd0, valid_out}, {31'd0, m_valid});
            check("rnd rom_addr", rom_addr, m_pc);
            check("rnd instr", instr_out, m_instr);
            check("rnd misalign", {31'd0, misalign_out}, {31'd0, m_mis});
            if (m_valid || r) begin
                check("rnd pc_out", pc_out, m_pco);
                check("rnd pc_plus4", pc_plus4_out, m_pc4);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
